// File: rtl/vec_ctrl_pkg.sv
// Shared types and defaults for the vector pipeline controller.
// Register index width and memory-wait state encoding live here.
package vec_ctrl_pkg;

    localparam int NREG_DEF   = 16;
    localparam int SB_LAT_DEF = 3;
    localparam int TO_MAX_DEF = 255;

    typedef logic [3:0] vreg_idx_t;

    typedef enum logic {
        M_IDLE = 1'b0,
        M_WAIT = 1'b1
    } mem_state_t;

endpackage

// File: rtl/vec_scoreboard.sv
// Per-register write-back scoreboard: a 2-bit down-counter per vector register.
// An issue loads SB_LAT, other non-zero counters count down, and freeze holds everything.
module vec_scoreboard
    import vec_ctrl_pkg::*;
#(
    parameter int NREG   = NREG_DEF,
    parameter int SB_LAT = SB_LAT_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    issue,
    input  logic [$clog2(NREG)-1:0] issue_idx,
    input  logic                    freeze,
    output logic [NREG-1:0]         pending
);

    localparam int         IW  = $clog2(NREG);
    localparam logic [1:0] LAT = 2'(SB_LAT);

    logic [1:0] sb [NREG];

    // A new issue to a register overrides its own decrement.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) begin
                sb[r] <= 2'd0;
            end
        end else if (!freeze) begin
            for (int r = 0; r < NREG; r++) begin
                if (issue && (issue_idx == IW'(r))) begin
                    sb[r] <= LAT;
                end else if (sb[r] != 2'd0) begin
                    sb[r] <= sb[r] - 2'd1;
                end
            end
        end
    end

    always_comb begin
        pending = '0;
        for (int r = 0; r < NREG; r++) begin
            pending[r] = (sb[r] != 2'd0);
        end
    end

endmodule

// File: rtl/vec_hazard_ctrl.sv
// Stall/flush controller for the D/E/M/W vector pipeline: RAW hazards and memory waits.
// Optional build macro VEC_HAZARD_PERF_EN adds a StallD cycle counter (stall_cnt).
//
// state  | meaning
// M_IDLE | no outstanding memory access beyond the current cycle
// M_WAIT | M-stage load/store not yet acknowledged; pipeline frozen while MemReqM & !mem_ready
module vec_hazard_ctrl
    import vec_ctrl_pkg::*;
#(
    parameter int NREG   = NREG_DEF,
    parameter int SB_LAT = SB_LAT_DEF,
    parameter int TO_MAX = TO_MAX_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [$clog2(NREG)-1:0] RA1D,
    input  logic [$clog2(NREG)-1:0] RA2D,
    input  logic                    UseRA1D,
    input  logic                    UseRA2D,
    input  logic [$clog2(NREG)-1:0] WA3D,
    input  logic                    RegWriteD,
    input  logic                    MemReqM,
    input  logic                    mem_ready,
    output logic                    StallF,
    output logic                    StallD,
    output logic                    FlushE,
    output logic                    StallE,
    output logic                    StallM,
    output logic                    FlushW,
    output logic                    mem_timeout
`ifdef VEC_HAZARD_PERF_EN
   ,output logic [31:0]             stall_cnt
`endif
);

    localparam int              TW     = $clog2(TO_MAX + 1);
    localparam logic [TW-1:0]   TO_LIM = TW'(TO_MAX);
    localparam logic [TW-1:0]   TO_PRE = TW'(TO_MAX - 1);

    logic [NREG-1:0] pending;
    logic            haz;
    logic            mstall;
    logic            issue;
    mem_state_t      state, state_nx;
    logic [TW-1:0]   to_cnt;

    assign mstall = MemReqM & ~mem_ready;
    assign haz    = (UseRA1D & pending[RA1D]) | (UseRA2D & pending[RA2D]);
    assign issue  = RegWriteD & ~haz & ~mstall;

    vec_scoreboard #(
        .NREG   (NREG),
        .SB_LAT (SB_LAT)
    ) u_sb (
        .clk       (clk),
        .reset     (reset),
        .issue     (issue),
        .issue_idx (WA3D),
        .freeze    (mstall),
        .pending   (pending)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= M_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // mstall outranks haz: a frozen pipeline must not also inject a bubble into E.
    always_comb begin
        state_nx = state;
        StallF   = 1'b0;
        StallD   = 1'b0;
        FlushE   = 1'b0;
        StallE   = 1'b0;
        StallM   = 1'b0;
        FlushW   = 1'b0;
        case (state)
            M_IDLE:  if (mstall)    state_nx = M_WAIT;
            M_WAIT:  if (mem_ready) state_nx = M_IDLE;
            default: state_nx = M_IDLE;
        endcase
        if (mstall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else if (haz) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
    end

    // Timeout keeps the FSM waiting; it only raises a sticky flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt      <= '0;
            mem_timeout <= 1'b0;
        end else begin
            if (state == M_IDLE && state_nx == M_WAIT) begin
                to_cnt <= '0;
            end else if (state == M_WAIT && to_cnt != TO_LIM) begin
                to_cnt <= to_cnt + TW'(1);
            end
            if (state == M_WAIT && to_cnt == TO_PRE) begin
                mem_timeout <= 1'b1;
            end
        end
    end

`ifdef VEC_HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (StallD) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`else
    // No stall counter in this build.
`endif

endmodule
